// File: rtl/spi_flash_responder.sv
// SPI flash target model (mode 0). Serves READ (0x03), JEDEC ID (0x9F) and
// STATUS (0x05) from an internal byte image loaded through a host write port.
// All SPI pins are synchronised into clk; protocol logic runs on edge pulses.
module spi_flash_responder #(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned ADDR_W    = 8,
    parameter logic [23:0] JEDEC_ID  = 24'hEF4016
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flash_cs_n,
    input  logic              flash_clk,
    input  logic              flash_mosi,
    output logic              flash_miso,
    input  logic              img_wen,
    input  logic [ADDR_W-1:0] img_waddr,
    input  logic [7:0]        img_wdata,
    output logic              busy,
    output logic              err_opcode,
    output logic [15:0]       rd_bytes
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StCmd    = 3'd1;
    localparam logic [2:0] StAddr   = 3'd2;
    localparam logic [2:0] StData   = 3'd3;
    localparam logic [2:0] StId     = 3'd4;
    localparam logic [2:0] StStat   = 3'd5;
    localparam logic [2:0] StIgnore = 3'd6;

    // Synchroniser and edge-detect state
    logic [1:0] cs_sync_q, sclk_sync_q, mosi_sync_q;
    logic       sclk_prev_q;
    logic [1:0] valid_q;
    logic       armed_q, armed_d;
    logic       cs_n_s, sclk_s, mosi_s, sclk_rise, sclk_fall;

    // Protocol state
    logic [2:0]        state_q, state_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        out_sr_q, out_sr_d;
    logic [2:0]        out_cnt_q, out_cnt_d;
    logic [1:0]        id_idx_q, id_idx_d;
    logic              miso_q, miso_d;
    logic              err_q, err_d;
    logic [15:0]       rd_bytes_q, rd_bytes_d;

    // Image storage and read port
    logic [7:0]        mem_q [MEM_DEPTH];
    logic [7:0]        rdata_q;
    logic              rd_en;
    logic [ADDR_W-1:0] raddr;

    logic [7:0]        cmd_shift;
    logic [ADDR_W-1:0] addr_shift;
    logic [7:0]        cur_byte;

    assign cs_n_s     = cs_sync_q[1];
    assign sclk_s     = sclk_sync_q[1];
    assign mosi_s     = mosi_sync_q[1];
    assign sclk_rise  = sclk_s & ~sclk_prev_q;
    assign sclk_fall  = ~sclk_s & sclk_prev_q;
    assign cmd_shift  = {cmd_q[6:0], mosi_s};
    assign addr_shift = {addr_q[ADDR_W-2:0], mosi_s};

    assign flash_miso = miso_q;
    assign busy       = ~cs_n_s;
    assign err_opcode = err_q;
    assign rd_bytes   = rd_bytes_q;

    // 2-FF synchronisers; cs_n resets high so busy reads 0 during reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_sync_q   <= 2'b11;
            sclk_sync_q <= 2'b00;
            mosi_sync_q <= 2'b00;
            sclk_prev_q <= 1'b0;
            valid_q     <= 2'b00;
            armed_q     <= 1'b0;
        end else begin
            cs_sync_q   <= {cs_sync_q[0], flash_cs_n};
            sclk_sync_q <= {sclk_sync_q[0], flash_clk};
            mosi_sync_q <= {mosi_sync_q[0], flash_mosi};
            sclk_prev_q <= sclk_s;
            valid_q     <= {valid_q[0], 1'b1};
            armed_q     <= armed_d;
        end
    end

    // Arm only once a real deselect has been seen since reset, so an
    // initiator that kept cs_n low across reset must re-select first.
    always_comb begin
        armed_d = armed_q | (valid_q[1] & cs_n_s);
    end

    // Byte presented at the start of each output byte
    always_comb begin
        cur_byte = 8'h00;
        case (state_q)
            StData: cur_byte = rdata_q;
            StId: begin
                case (id_idx_q)
                    2'd0:    cur_byte = JEDEC_ID[23:16];
                    2'd1:    cur_byte = JEDEC_ID[15:8];
                    2'd2:    cur_byte = JEDEC_ID[7:0];
                    default: cur_byte = 8'h00;
                endcase
            end
            default: cur_byte = 8'h00;
        endcase
    end

    // Protocol FSM next-state logic
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        cmd_d      = cmd_q;
        addr_d     = addr_q;
        out_sr_d   = out_sr_q;
        out_cnt_d  = out_cnt_q;
        id_idx_d   = id_idx_q;
        miso_d     = miso_q;
        err_d      = err_q;
        rd_bytes_d = rd_bytes_q;
        rd_en      = 1'b0;
        raddr      = addr_q;

        if (cs_n_s) begin
            state_d   = StIdle;
            bit_cnt_d = 5'd0;
            out_cnt_d = 3'd0;
            id_idx_d  = 2'd0;
            miso_d    = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (armed_q) begin
                        state_d   = StCmd;
                        bit_cnt_d = 5'd0;
                    end
                end
                StCmd: begin
                    if (sclk_rise) begin
                        cmd_d     = cmd_shift;
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d = 5'd0;
                            out_cnt_d = 3'd0;
                            id_idx_d  = 2'd0;
                            case (cmd_shift)
                                8'h03: state_d = StAddr;
                                8'h9F: state_d = StId;
                                8'h05: state_d = StStat;
                                default: begin
                                    err_d   = 1'b1;
                                    state_d = StIgnore;
                                end
                            endcase
                        end
                    end
                end
                StAddr: begin
                    if (sclk_rise) begin
                        addr_d    = addr_shift;
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd23) begin
                            // Read issued here lands in rdata_q well before the next fall
                            rd_en     = 1'b1;
                            raddr     = addr_shift;
                            bit_cnt_d = 5'd0;
                            out_cnt_d = 3'd0;
                            state_d   = StData;
                        end
                    end
                end
                StData, StId, StStat: begin
                    if (sclk_fall) begin
                        if (out_cnt_q == 3'd0) begin
                            miso_d   = cur_byte[7];
                            out_sr_d = {cur_byte[6:0], 1'b0};
                        end else begin
                            miso_d   = out_sr_q[7];
                            out_sr_d = {out_sr_q[6:0], 1'b0};
                        end
                        out_cnt_d = out_cnt_q + 3'd1;
                        if (out_cnt_q == 3'd7) begin
                            if (state_q == StData) begin
                                // Last bit now on the wire: count it and prefetch the next byte
                                rd_bytes_d = rd_bytes_q + 16'd1;
                                addr_d     = addr_q + ADDR_W'(1);
                                rd_en      = 1'b1;
                                raddr      = addr_q + ADDR_W'(1);
                            end else if (state_q == StId && id_idx_q != 2'd3) begin
                                id_idx_d = id_idx_q + 2'd1;
                            end
                        end
                    end
                end
                StIgnore: miso_d = 1'b0;
                default:  state_d = StIdle;
            endcase
        end
    end

    // Protocol state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            bit_cnt_q  <= 5'd0;
            cmd_q      <= 8'h00;
            addr_q     <= '0;
            out_sr_q   <= 8'h00;
            out_cnt_q  <= 3'd0;
            id_idx_q   <= 2'd0;
            miso_q     <= 1'b0;
            err_q      <= 1'b0;
            rd_bytes_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            out_sr_q   <= out_sr_d;
            out_cnt_q  <= out_cnt_d;
            id_idx_q   <= id_idx_d;
            miso_q     <= miso_d;
            err_q      <= err_d;
            rd_bytes_q <= rd_bytes_d;
        end
    end

    // Image array: survives reset; a same-cycle read sees the pre-write byte
    always_ff @(posedge clk) begin
        if (img_wen) begin
            mem_q[img_waddr] <= img_wdata;
        end
        if (rd_en) begin
            rdata_q <= mem_q[raddr];
        end
    end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Self-checking bench for spi_flash_responder: a bit-banged SPI initiator
// plus a byte-array model of the flash image and the byte counter.
module tb_spi_flash_responder;

    localparam int HALF = 8;  // clk cycles per SPI half period

    logic        clk;
    logic        rst;
    logic        flash_cs_n;
    logic        flash_clk;
    logic        flash_mosi;
    logic        flash_miso;
    logic        img_wen;
    logic [7:0]  img_waddr;
    logic [7:0]  img_wdata;
    logic        busy;
    logic        err_opcode;
    logic [15:0] rd_bytes;

    int          total;
    int          bad;
    logic [7:0]  model_mem [256];
    int          model_rd_bytes;
    logic        model_err;
    logic [7:0]  rx_buf [16];

    spi_flash_responder #(
        .MEM_DEPTH(256),
        .ADDR_W   (8),
        .JEDEC_ID (24'hEF4016)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flash_cs_n (flash_cs_n),
        .flash_clk  (flash_clk),
        .flash_mosi (flash_mosi),
        .flash_miso (flash_miso),
        .img_wen    (img_wen),
        .img_waddr  (img_waddr),
        .img_wdata  (img_wdata),
        .busy       (busy),
        .err_opcode (err_opcode),
        .rd_bytes   (rd_bytes)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_byte(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        img_wen   = 1'b1;
        img_waddr = a;
        img_wdata = d;
        @(negedge clk);
        img_wen   = 1'b0;
        model_mem[a] = d;
    endtask

    // Mode-0 initiator: drive mosi while sclk low, sample miso at the rise
    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < n; i++) begin
            flash_mosi = tx[7-i];
            wait_clks(HALF);
            flash_clk = 1'b1;
            rx = {rx[6:0], flash_miso};
            wait_clks(HALF);
            flash_clk = 1'b0;
        end
    endtask

    task automatic spi_select();
        wait_clks(4);
        flash_cs_n = 1'b0;
        wait_clks(HALF);
    endtask

    task automatic spi_deselect();
        wait_clks(HALF);
        flash_cs_n = 1'b1;
        wait_clks(8);
    endtask

    // Opcode + 3 address bytes + n data bytes into rx_buf; leaves cs_n low
    task automatic do_read(input logic [23:0] addr, input int n);
        logic [7:0] r;
        spi_select();
        spi_bits(8'h03, 8, r);
        spi_bits(addr[23:16], 8, r);
        spi_bits(addr[15:8], 8, r);
        spi_bits(addr[7:0], 8, r);
        for (int i = 0; i < n; i++) begin
            spi_bits(8'($urandom), 8, r);
            rx_buf[i] = r;
        end
    endtask

    task automatic do_opcode(input logic [7:0] op, input int n);
        logic [7:0] r;
        spi_select();
        spi_bits(op, 8, r);
        for (int i = 0; i < n; i++) begin
            spi_bits(8'($urandom), 8, r);
            rx_buf[i] = r;
        end
    endtask

    task automatic test_reset();
        wait_clks(3);
        #1;
        total++;
        if (flash_miso !== 1'b0) begin bad++; $display("FAIL reset_miso: got %b want 0", flash_miso); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++;
        if (err_opcode !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err_opcode); end
        total++;
        if (rd_bytes !== 16'd0) begin bad++; $display("FAIL reset_rd_bytes: got %0d want 0", rd_bytes); end
        @(negedge clk);
        rst = 1'b0;
        wait_clks(6);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic load_full_image();
        for (int a = 0; a < 256; a++) load_byte(8'(a), 8'($urandom));
    endtask

    task automatic test_read_basic();
        load_byte(8'h00, 8'hA5);
        load_byte(8'h01, 8'h3C);
        load_byte(8'h02, 8'h0F);
        load_byte(8'h03, 8'hF0);
        do_read(24'h000000, 4);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy: got %b want 1", busy); end
        spi_deselect();
        model_rd_bytes += 4;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (rx_buf[i] !== model_mem[i]) begin
                bad++;
                $display("FAIL basic_byte%0d: got %h want %h", i, rx_buf[i], model_mem[i]);
            end
        end
        total++;
        if (rd_bytes !== 16'(model_rd_bytes)) begin
            bad++; $display("FAIL basic_rd_bytes: got %0d want %0d", rd_bytes, model_rd_bytes);
        end
        total++;
        if (err_opcode !== 1'b0) begin bad++; $display("FAIL basic_err: got %b want 0", err_opcode); end
        total++;
        if (busy !== 1'b0 || flash_miso !== 1'b0) begin
            bad++; $display("FAIL basic_idle: got busy=%b miso=%b want 0 0", busy, flash_miso);
        end
    endtask

    task automatic test_read_wrap();
        logic [7:0] exp;
        load_byte(8'hFE, 8'h11);
        load_byte(8'hFF, 8'h22);
        load_byte(8'h00, 8'h33);
        do_read(24'h0100FE, 3);
        spi_deselect();
        model_rd_bytes += 3;
        for (int i = 0; i < 3; i++) begin
            exp = model_mem[(254 + i) % 256];
            total++;
            if (rx_buf[i] !== exp) begin
                bad++; $display("FAIL wrap_byte%0d: got %h want %h", i, rx_buf[i], exp);
            end
        end
        total++;
        if (rd_bytes !== 16'(model_rd_bytes)) begin
            bad++; $display("FAIL wrap_rd_bytes: got %0d want %0d", rd_bytes, model_rd_bytes);
        end
    endtask

    task automatic test_id_status();
        logic [7:0] id_exp [5];
        id_exp[0] = 8'hEF; id_exp[1] = 8'h40; id_exp[2] = 8'h16;
        id_exp[3] = 8'h00; id_exp[4] = 8'h00;
        do_opcode(8'h9F, 5);
        spi_deselect();
        for (int i = 0; i < 5; i++) begin
            total++;
            if (rx_buf[i] !== id_exp[i]) begin
                bad++; $display("FAIL id_byte%0d: got %h want %h", i, rx_buf[i], id_exp[i]);
            end
        end
        do_opcode(8'h05, 2);
        spi_deselect();
        for (int i = 0; i < 2; i++) begin
            total++;
            if (rx_buf[i] !== 8'h00) begin
                bad++; $display("FAIL stat_byte%0d: got %h want 00", i, rx_buf[i]);
            end
        end
        total++;
        if (err_opcode !== 1'b0 || rd_bytes !== 16'(model_rd_bytes)) begin
            bad++; $display("FAIL id_side_effects: got err=%b rd=%0d want 0 %0d",
                            err_opcode, rd_bytes, model_rd_bytes);
        end
    endtask

    task automatic test_bad_opcode();
        load_byte(8'h00, 8'hA5);
        do_opcode(8'hAB, 2);
        spi_deselect();
        model_err = 1'b1;
        for (int i = 0; i < 2; i++) begin
            total++;
            if (rx_buf[i] !== 8'h00) begin
                bad++; $display("FAIL badop_byte%0d: got %h want 00", i, rx_buf[i]);
            end
        end
        total++;
        if (err_opcode !== model_err) begin bad++; $display("FAIL badop_err: got %b want 1", err_opcode); end
        do_read(24'h000000, 1);
        spi_deselect();
        model_rd_bytes += 1;
        total++;
        if (rx_buf[0] !== model_mem[0]) begin
            bad++; $display("FAIL badop_read: got %h want %h", rx_buf[0], model_mem[0]);
        end
        total++;
        if (err_opcode !== model_err) begin bad++; $display("FAIL badop_sticky: got %b want 1", err_opcode); end
    endtask

    task automatic test_abort();
        logic [7:0] r;
        spi_select();
        spi_bits(8'h03, 8, r);
        spi_bits(8'h00, 3, r);
        spi_deselect();
        total++;
        if (rd_bytes !== 16'(model_rd_bytes) || busy !== 1'b0) begin
            bad++; $display("FAIL abort_state: got rd=%0d busy=%b want %0d 0",
                            rd_bytes, busy, model_rd_bytes);
        end
        do_read(24'h000002, 1);
        spi_deselect();
        model_rd_bytes += 1;
        total++;
        if (rx_buf[0] !== model_mem[2]) begin
            bad++; $display("FAIL abort_read: got %h want %h", rx_buf[0], model_mem[2]);
        end
        total++;
        if (rd_bytes !== 16'(model_rd_bytes)) begin
            bad++; $display("FAIL abort_rd_bytes: got %0d want %0d", rd_bytes, model_rd_bytes);
        end
    endtask

    // Byte after the one in flight is already prefetched; the one after that is not
    task automatic test_write_during_read();
        logic [7:0] a, r, old1, new2;
        a = 8'($urandom);
        do_read({16'h0000, a}, 1);
        old1 = model_mem[8'(a + 8'd1)];
        load_byte(8'(a + 8'd1), ~old1);
        new2 = ~model_mem[8'(a + 8'd2)];
        load_byte(8'(a + 8'd2), new2);
        spi_bits(8'h00, 8, r);
        rx_buf[1] = r;
        spi_bits(8'h00, 8, r);
        rx_buf[2] = r;
        spi_deselect();
        model_rd_bytes += 3;
        total++;
        if (rx_buf[1] !== old1) begin
            bad++; $display("FAIL wdr_prefetched: got %h want %h", rx_buf[1], old1);
        end
        total++;
        if (rx_buf[2] !== new2) begin
            bad++; $display("FAIL wdr_later: got %h want %h", rx_buf[2], new2);
        end
    endtask

    task automatic test_random_reads();
        logic [23:0] addr;
        logic [7:0]  exp;
        int          n;
        for (int it = 0; it < 6; it++) begin
            for (int w = 0; w < 6; w++) load_byte(8'($urandom), 8'($urandom));
            addr = 24'($urandom);
            n = $urandom_range(1, 5);
            do_read(addr, n);
            spi_deselect();
            model_rd_bytes += n;
            for (int i = 0; i < n; i++) begin
                exp = model_mem[(int'(addr[7:0]) + i) % 256];
                total++;
                if (rx_buf[i] !== exp) begin
                    bad++; $display("FAIL rand%0d_byte%0d (addr %h): got %h want %h",
                                    it, i, addr, rx_buf[i], exp);
                end
            end
            total++;
            if (rd_bytes !== 16'(model_rd_bytes) || err_opcode !== model_err) begin
                bad++; $display("FAIL rand%0d_status: got rd=%0d err=%b want %0d %b",
                                it, rd_bytes, err_opcode, model_rd_bytes, model_err);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] r;
        load_byte(8'h01, 8'h3C);
        do_read(24'h000000, 1);
        spi_bits(8'h00, 4, r);
        model_rd_bytes += 1;
        total++;
        if (rd_bytes !== 16'(model_rd_bytes)) begin
            bad++; $display("FAIL rstmid_pre: got %0d want %0d", rd_bytes, model_rd_bytes);
        end
        rst = 1'b1;
        #1;
        model_rd_bytes = 0;
        model_err      = 1'b0;
        total++;
        if (flash_miso !== 1'b0 || busy !== 1'b0 || rd_bytes !== 16'd0 || err_opcode !== 1'b0) begin
            bad++; $display("FAIL rstmid_async: got miso=%b busy=%b rd=%0d err=%b want 0 0 0 0",
                            flash_miso, busy, rd_bytes, err_opcode);
        end
        wait_clks(3);
        rst = 1'b0;
        wait_clks(6);
        // Still selected across reset: target must stay silent until re-selected
        spi_bits(8'h9F, 8, r);
        spi_bits(8'h00, 8, r);
        total++;
        if (r !== 8'h00 || err_opcode !== 1'b0) begin
            bad++; $display("FAIL rstmid_noreselect: got %h err=%b want 00 0", r, err_opcode);
        end
        spi_deselect();
        do_read(24'h000001, 1);
        spi_deselect();
        model_rd_bytes += 1;
        total++;
        if (rx_buf[0] !== model_mem[1]) begin
            bad++; $display("FAIL rstmid_read: got %h want %h", rx_buf[0], model_mem[1]);
        end
        total++;
        if (rd_bytes !== 16'(model_rd_bytes)) begin
            bad++; $display("FAIL rstmid_rd_bytes: got %0d want %0d", rd_bytes, model_rd_bytes);
        end
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        model_rd_bytes = 0;
        model_err      = 1'b0;
        rst            = 1'b1;
        flash_cs_n     = 1'b1;
        flash_clk      = 1'b0;
        flash_mosi     = 1'b0;
        img_wen        = 1'b0;
        img_waddr      = 8'h00;
        img_wdata      = 8'h00;
        for (int i = 0; i < 16; i++) rx_buf[i] = 8'h00;

        test_reset();
        load_full_image();
        test_read_basic();
        test_read_wrap();
        test_id_status();
        test_bad_opcode();
        test_abort();
        test_write_during_read();
        test_random_reads();
        test_reset_mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_flash_responder.md
Name: spi_flash_responder

Overview:
SPI flash target model that answers the SPI read sequences issued by the mesh boot controller. It serves a boot image from an internal byte array, which a host loads through a simple write port. It sits at the flash end of the flash_cs_n/flash_clk/flash_mosi/flash_miso link. It is used in FPGA bring-up and in full-chip simulation in place of an external flash part.

Parameters:
MEM_DEPTH, 256, image size in bytes; power of two.
ADDR_W, 8, log2(MEM_DEPTH); width of the image write address.
JEDEC_ID, 24'hEF4016, 3 bytes returned MSB-first for opcode 0x9F.

Ports:
clk  in  1  system clock; must run at ≥4x flash_clk frequency
rst  in  1  reset; asynchronous, active-high
flash_cs_n  in  1  chip select from initiator, active-low
flash_clk  in  1  SPI clock, mode 0 (idle low)
flash_mosi  in  1  initiator-to-target data, MSB first
flash_miso  out  1  target-to-initiator data, MSB first
img_wen  in  1  image write strobe, one byte per cycle
img_waddr  in  ADDR_W  image write address
img_wdata  in  8  image write data
busy  out  1  high while cs_n (synchronised) is low
err_opcode  out  1  sticky; set on an unsupported opcode, cleared only by rst
rd_bytes  out  16  count of data bytes shifted out by READ; wraps at 0xFFFF

Behaviour:
- Reset (async, rst=1): flash_miso=0, busy=0, err_opcode=0, rd_bytes=0. FSM goes to IDLE. Image contents are not cleared.
- Input synchronisation: cs_n, sclk and mosi each pass through 2-FF synchronisers.
  - sclk rise/fall is detected from the last two synchronised samples.
  - All protocol logic runs on clk, using these edge pulses.
- Sampling and driving:
  - Sample mosi on a detected sclk rise.
  - Update miso on a detected sclk fall.
  - The first bit of each output byte is driven on the fall that ends the preceding byte.
  - miso=0 whenever no output byte is active.
- Framing:
  - Synchronised cs_n high forces IDLE, clears the bit counter and sets miso=0 within 3 clk.
  - cs_n rising mid-byte aborts the transaction with no side effects.
- FSM states:
  - IDLE -> CMD when synchronised cs_n falls.
  - CMD: shift in 8 bits, then decode:
    - 0x03 -> ADDR.
    - 0x9F -> ID.
    - 0x05 -> STAT.
    - other -> set err_opcode, go to IGNORE.
  - ADDR: shift in 24 bits. The address is taken modulo MEM_DEPTH; upper bits are ignored.
    - On the rise of bit 24, issue the image read (registered, 1-cycle latency).
    - Load the byte into the output shift register before the next sclk fall.
    - Go to DATA.
  - DATA: shift out the current byte. On its 8th fall-out, increment rd_bytes and prefetch address+1.
    - The address wraps from MEM_DEPTH-1 to 0.
    - Reading continues unbounded until cs_n goes high.
  - ID: shift out JEDEC_ID[23:16], [15:8], [7:0], then 0x00 repeatedly.
  - STAT: shift out 0x00 repeatedly (never busy).
  - IGNORE: miso=0 until cs_n goes high.
- Image write port:
  - A write with img_wen=1 takes effect at the clk edge; it is allowed at any time.
  - A write to the address of a byte that has already been prefetched does not alter that byte. Later bytes see the new data.
  - Write and read in the same cycle to the same address: the read returns the old data.
- mosi during DATA/ID/STAT is ignored.
- cs_n low with no sclk edges: state holds indefinitely.
- Reset asserted mid-transaction: immediate return to the reset values. The initiator must re-select before the target responds again.

Test Plan:
- Load img[0x00..0x03]=A5,3C,0F,F0; issue cs low, 0x03, addr 0x000000, read 4 bytes -> MISO bytes A5,3C,0F,F0; rd_bytes=4; err_opcode=0.
- Load img[0xFE]=11, img[0xFF]=22, img[0x00]=33; READ addr 0x0100FE, 3 bytes -> 11,22,33 (upper address bits ignored, wrap at 255->0).
- Opcode 0x9F, 5 bytes -> EF,40,16,00,00; opcode 0x05, 1 byte -> 00.
- Opcode 0xAB -> miso stays 0 for 2 following bytes, err_opcode=1. A subsequent READ of addr 0x000000 still returns A5; err_opcode remains 1.
- Deassert cs_n after 3 bits of the address, then run a new READ of addr 0x000002 -> returns 0F; rd_bytes increments only for completed bytes.
- Assert rst during the 2nd data byte -> flash_miso=0, busy=0, rd_bytes=0 asynchronously. After release plus a new cs cycle, READ of 0x000001 -> 3C.
